// File: rtl/mem_req_arbiter.sv
// Two-port round-robin arbiter that serialises requests onto a single memory controller.
// Optional WAIT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter #(
   parameter int ADDR_WIDTH_EXT = 20,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      m0_req,
   input  logic                      m0_we,
   input  logic [ADDR_WIDTH_EXT-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0]     m0_wdata,
   output logic                      m0_ack,
   output logic                      m0_err,
   output logic [DATA_WIDTH-1:0]     m0_rdata,
   input  logic                      m1_req,
   input  logic                      m1_we,
   input  logic [ADDR_WIDTH_EXT-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0]     m1_wdata,
   output logic                      m1_ack,
   output logic                      m1_err,
   output logic [DATA_WIDTH-1:0]     m1_rdata,
   output logic                      mc_we,
   output logic                      mc_re,
   output logic [ADDR_WIDTH_EXT-1:0] mc_addr,
   output logic [DATA_WIDTH-1:0]     mc_data_in,
   input  logic [DATA_WIDTH-1:0]     mc_data_out,
   input  logic                      mc_busy,
   input  logic                      mc_done,
   output logic                      arb_busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 1..255");
   end

   logic [1:0]                state_q, state_d;
   logic                      last_q, last_d;
   logic                      win_q, win_d;
   logic                      we_q, we_d;
   logic [ADDR_WIDTH_EXT-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]     rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0]     rdata1_q, rdata1_d;
   logic                      grant1;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYCLES);
   logic       err_q, err_d;
   logic [7:0] wdog_q, wdog_d;
`endif

   // With both ports requesting, the one not granted last wins.
   assign grant1 = (m0_req && m1_req) ? ~last_q : m1_req;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      win_d    = win_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
`ifdef MEM_ARB_TIMEOUT_EN
      err_d    = err_q;
      wdog_d   = wdog_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if ((m0_req || m1_req) && !mc_busy) begin
               win_d   = grant1;
               we_d    = grant1 ? m1_we    : m0_we;
               addr_d  = grant1 ? m1_addr  : m0_addr;
               wdata_d = grant1 ? m1_wdata : m0_wdata;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
`ifdef MEM_ARB_TIMEOUT_EN
            wdog_d  = 8'd0;
`endif
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mc_done) begin
               if (!we_q) begin
                  if (win_q) rdata1_d = mc_data_out;
                  else       rdata0_d = mc_data_out;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = ST_RESP;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else begin
               wdog_d = wdog_q + 8'd1;
               if (wdog_d == WDOG_LIMIT) begin
                  err_d = 1'b1;
                  if (win_q) rdata1_d = '0;
                  else       rdata0_d = '0;
                  state_d = ST_RESP;
               end
            end
`endif
         end
         ST_RESP: begin
            last_d  = win_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         last_q   <= 1'b1;
         win_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         err_q    <= 1'b0;
         wdog_q   <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         win_q    <= win_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
`ifdef MEM_ARB_TIMEOUT_EN
         err_q    <= err_d;
         wdog_q   <= wdog_d;
`endif
      end
   end

   assign mc_we      = (state_q == ST_ISSUE) &&  we_q;
   assign mc_re      = (state_q == ST_ISSUE) && !we_q;
   assign mc_addr    = addr_q;
   assign mc_data_in = wdata_q;
   assign m0_ack     = (state_q == ST_RESP) && !win_q;
   assign m1_ack     = (state_q == ST_RESP) &&  win_q;
   assign m0_rdata   = rdata0_q;
   assign m1_rdata   = rdata1_q;
   assign arb_busy   = (state_q != ST_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
   assign m0_err = m0_ack && err_q;
   assign m1_err = m1_ack && err_q;
`else
   assign m0_err = 1'b0;
   assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: expected commands and acks are queued by the
// stimulus and checked by a negedge monitor; a small controller model answers strobes.
module tb_mem_req_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TB_TIMEOUT = 4;
`else
   localparam int TB_TIMEOUT = 255;
`endif

   typedef struct packed {
      logic        we;
      logic [19:0] addr;
      logic [7:0]  data;
   } cmd_t;

   typedef struct packed {
      logic       port;
      logic       err;
      logic [7:0] rdata;
   } ack_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [19:0] m0_addr = '0;
   logic [7:0]  m0_wdata = '0;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [19:0] m1_addr = '0;
   logic [7:0]  m1_wdata = '0;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [7:0]  m0_rdata, m1_rdata;
   logic        mc_we, mc_re, arb_busy;
   logic [19:0] mc_addr;
   logic [7:0]  mc_data_in;
   logic [7:0]  mc_data_out = '0;
   logic        mc_busy = 1'b0;
   logic        model_done = 1'b0;
   logic        manual_done = 1'b0;
   logic        mc_done;

   int   ctrl_delay = 3;
   logic [7:0] ctrl_rdata = '0;
   logic ctrl_en = 1'b1;

   int cyc = 0;
   int total_checks = 0;
   int passed_checks = 0;
   int strobe_count = 0;
   int ack_count = 0;
   int strobe_cyc[$];
   int ack_cyc[$];
   cmd_t cmd_q[$];
   ack_t ack_q[$];

   assign mc_done = model_done | manual_done;

   mem_req_arbiter #(
      .ADDR_WIDTH_EXT(20),
      .DATA_WIDTH(8),
      .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mc_we(mc_we), .mc_re(mc_re), .mc_addr(mc_addr), .mc_data_in(mc_data_in),
      .mc_data_out(mc_data_out), .mc_busy(mc_busy), .mc_done(mc_done),
      .arb_busy(arb_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_checks++;
      if (act === exp) passed_checks++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // Controller model: answers each strobe with mc_done after ctrl_delay cycles.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if ((mc_we || mc_re) && ctrl_en) begin
            repeat (ctrl_delay) @(posedge clk);
            #1;
            model_done  = 1'b1;
            mc_data_out = ctrl_rdata;
            @(posedge clk);
            #1;
            model_done  = 1'b0;
            mc_data_out = '0;
         end
      end
   end

   // Monitor: compares every strobe and every ack against the scoreboard queues.
   always @(negedge clk) begin
      if (mc_we || mc_re) begin
         cmd_t e;
         strobe_cyc.push_back(cyc);
         strobe_count++;
         check_output("strobe_onehot", {31'd0, mc_we & mc_re}, 32'd0);
         if (cmd_q.size() == 0) begin
            check_output("unexpected_cmd", 32'd1, 32'd0);
         end else begin
            e = cmd_q.pop_front();
            check_output("cmd_we", {31'd0, mc_we}, {31'd0, e.we});
            check_output("cmd_addr", {12'd0, mc_addr}, {12'd0, e.addr});
            check_output("cmd_data", {24'd0, mc_data_in}, {24'd0, e.data});
         end
      end
      if (m0_ack || m1_ack) begin
         ack_t a;
         ack_cyc.push_back(cyc);
         ack_count++;
         check_output("ack_onehot", {31'd0, m0_ack & m1_ack}, 32'd0);
         if (ack_q.size() == 0) begin
            check_output("unexpected_ack", 32'd1, 32'd0);
         end else begin
            a = ack_q.pop_front();
            check_output("ack_port", {31'd0, m1_ack}, {31'd0, a.port});
            check_output("ack_err", {31'd0, m1_ack ? m1_err : m0_err}, {31'd0, a.err});
            check_output("ack_rdata", {24'd0, m1_ack ? m1_rdata : m0_rdata}, {24'd0, a.rdata});
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got running, required finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   task automatic wait_acks(input int target, input int budget, input string name);
      int n = 0;
      while (ack_count < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (ack_count < target) check_output({name, "_timeout"}, ack_count, target);
   endtask

   task automatic wait_strobes(input int target, input int budget, input string name);
      int n = 0;
      while (strobe_count < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (strobe_count < target) check_output({name, "_timeout"}, strobe_count, target);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_output({tag, "_m0_ack"}, {31'd0, m0_ack}, 32'd0);
      check_output({tag, "_m1_ack"}, {31'd0, m1_ack}, 32'd0);
      check_output({tag, "_m0_err"}, {31'd0, m0_err}, 32'd0);
      check_output({tag, "_m1_err"}, {31'd0, m1_err}, 32'd0);
      check_output({tag, "_m0_rdata"}, {24'd0, m0_rdata}, 32'd0);
      check_output({tag, "_m1_rdata"}, {24'd0, m1_rdata}, 32'd0);
      check_output({tag, "_mc_we"}, {31'd0, mc_we}, 32'd0);
      check_output({tag, "_mc_re"}, {31'd0, mc_re}, 32'd0);
      check_output({tag, "_mc_addr"}, {12'd0, mc_addr}, 32'd0);
      check_output({tag, "_mc_data_in"}, {24'd0, mc_data_in}, 32'd0);
      check_output({tag, "_arb_busy"}, {31'd0, arb_busy}, 32'd0);
   endtask

   initial begin
      int req_cyc, rel_cyc, sb, ab, sc, ac;

      // Reset state
      apply_reset();
      @(negedge clk);
      check_idle_outputs("reset");

      // m0 write, controller done 3 cycles after the strobe
      ctrl_delay = 3;
      @(posedge clk);
      #1;
      m0_we = 1'b1; m0_addr = 20'h00010; m0_wdata = 8'hA5; m0_req = 1'b1;
      req_cyc = cyc;
      cmd_q.push_back('{we: 1'b1, addr: 20'h00010, data: 8'hA5});
      ack_q.push_back('{port: 1'b0, err: 1'b0, rdata: 8'h00});
      wait_acks(ack_count + 1, 40, "m0_write");
      @(posedge clk);
      #1;
      m0_req = 1'b0;
      check_output("wr_strobe_latency", strobe_cyc[$] - req_cyc, 1);
      check_output("wr_ack_latency", ack_cyc[$] - strobe_cyc[$], 4);
      check_output("wr_leaves_rdata", {24'd0, m0_rdata}, 32'd0);

      // Round robin from reset: m0 wins first, then strict alternation
      apply_reset();
      ctrl_delay = 1;
      ctrl_rdata = 8'h5A;
      sb = strobe_cyc.size();
      ab = ack_cyc.size();
      ac = ack_count;
      m0_we = 1'b1; m0_addr = 20'h00100; m0_wdata = 8'h11;
      m1_we = 1'b0; m1_addr = 20'h00200; m1_wdata = 8'h22;
      for (int i = 0; i < 2; i++) begin
         cmd_q.push_back('{we: 1'b1, addr: 20'h00100, data: 8'h11});
         ack_q.push_back('{port: 1'b0, err: 1'b0, rdata: 8'h00});
         cmd_q.push_back('{we: 1'b0, addr: 20'h00200, data: 8'h22});
         ack_q.push_back('{port: 1'b1, err: 1'b0, rdata: 8'h5A});
      end
      m0_req = 1'b1;
      m1_req = 1'b1;
      wait_acks(ac + 4, 80, "round_robin");
      @(posedge clk);
      #1;
      m0_req = 1'b0;
      m1_req = 1'b0;
      if (ack_cyc.size() >= ab + 4 && strobe_cyc.size() >= sb + 4) begin
         for (int i = 0; i < 3; i++)
            check_output($sformatf("rr_turnaround_%0d", i), strobe_cyc[sb+i+1] - ack_cyc[ab+i], 2);
      end else begin
         check_output("rr_event_count", ack_cyc.size() - ab, 4);
      end

      // m1 read returning 0x3C, held after the ack
      ctrl_delay = 2;
      ctrl_rdata = 8'h3C;
      @(posedge clk);
      #1;
      m1_we = 1'b0; m1_addr = 20'h12345; m1_wdata = 8'h77; m1_req = 1'b1;
      cmd_q.push_back('{we: 1'b0, addr: 20'h12345, data: 8'h77});
      ack_q.push_back('{port: 1'b1, err: 1'b0, rdata: 8'h3C});
      wait_acks(ack_count + 1, 40, "m1_read");
      @(posedge clk);
      #1;
      m1_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_output("rd_rdata_held", {24'd0, m1_rdata}, 32'h3C);
      check_output("rd_other_rdata", {24'd0, m0_rdata}, 32'h00);
      check_output("rd_addr_held", {12'd0, mc_addr}, 32'h12345);
      check_output("rd_idle_busy", {31'd0, arb_busy}, 32'd0);

      // mc_busy blocks the grant for 10 cycles
      ctrl_delay = 2;
      ctrl_rdata = 8'hC3;
      mc_busy = 1'b1;
      m0_we = 1'b0; m0_addr = 20'h0ABCD; m0_wdata = 8'h00; m0_req = 1'b1;
      cmd_q.push_back('{we: 1'b0, addr: 20'h0ABCD, data: 8'h00});
      ack_q.push_back('{port: 1'b0, err: 1'b0, rdata: 8'hC3});
      sc = strobe_count;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      check_output("busy_no_strobe", strobe_count - sc, 0);
      check_output("busy_stays_idle", {31'd0, arb_busy}, 32'd0);
      mc_busy = 1'b0;
      rel_cyc = cyc;
      wait_strobes(sc + 1, 10, "busy_release");
      if (strobe_count > sc) check_output("busy_issue_cycle", strobe_cyc[$] - rel_cyc, 1);
      wait_acks(ack_count + 1, 40, "busy_read");
      @(posedge clk);
      #1;
      m0_req = 1'b0;
      check_output("busy_other_rdata", {24'd0, m1_rdata}, 32'h3C);

      // Reset during WAIT aborts without an ack; the late mc_done is ignored
      ctrl_delay = 5;
      ctrl_rdata = 8'hEE;
      ac = ack_count;
      sc = strobe_count;
      @(posedge clk);
      #1;
      m1_we = 1'b1; m1_addr = 20'h00FFF; m1_wdata = 8'h99; m1_req = 1'b1;
      cmd_q.push_back('{we: 1'b1, addr: 20'h00FFF, data: 8'h99});
      wait_strobes(sc + 1, 10, "abort_issue");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      m1_req = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check_output("abort_no_ack", ack_count - ac, 0);
      check_idle_outputs("abort");

`ifdef MEM_ARB_TIMEOUT_EN
      // Watchdog: a good read first, then a read the controller never answers
      ctrl_en = 1'b1;
      ctrl_delay = 2;
      ctrl_rdata = 8'h6B;
      @(posedge clk);
      #1;
      m0_we = 1'b0; m0_addr = 20'h00042; m0_wdata = 8'h00; m0_req = 1'b1;
      cmd_q.push_back('{we: 1'b0, addr: 20'h00042, data: 8'h00});
      ack_q.push_back('{port: 1'b0, err: 1'b0, rdata: 8'h6B});
      wait_acks(ack_count + 1, 40, "pre_timeout_read");
      @(posedge clk);
      #1;
      m0_req = 1'b0;
      ctrl_en = 1'b0;
      @(posedge clk);
      #1;
      m0_addr = 20'h00043; m0_req = 1'b1;
      cmd_q.push_back('{we: 1'b0, addr: 20'h00043, data: 8'h00});
      ack_q.push_back('{port: 1'b0, err: 1'b1, rdata: 8'h00});
      wait_acks(ack_count + 1, 40, "timeout_read");
      @(posedge clk);
      #1;
      m0_req = 1'b0;
      check_output("timeout_latency", ack_cyc[$] - strobe_cyc[$], 5);
      ac = ack_count;
      manual_done = 1'b1;
      @(posedge clk);
      #1;
      manual_done = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_output("late_done_ignored", ack_count - ac, 0);
      check_output("late_done_idle", {31'd0, arb_busy}, 32'd0);
      check_output("timeout_rdata_held", {24'd0, m0_rdata}, 32'd0);
`endif

      check_output("scoreboard_cmd_drained", cmd_q.size(), 0);
      check_output("scoreboard_ack_drained", ack_q.size(), 0);
      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH_EXT, default 20, sets the width of the requester and controller address.
REQ-002 Parameter DATA_WIDTH, default 8, sets the data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, sets the watchdog limit in WAIT (range 1..255).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-005 clk  in  1  clock; all logic is clocked on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 mN_req  in  1  (N=0,1) request; held until mN_ack.
REQ-008 mN_we  in  1  1=write, 0=read; stable while mN_req is high.
REQ-009 mN_addr  in  ADDR_WIDTH_EXT  address; stable while mN_req is high.
REQ-010 mN_wdata  in  DATA_WIDTH  write data; stable while mN_req is high.
REQ-011 mN_ack  out  1  one-cycle completion pulse.
REQ-012 mN_err  out  1  timeout flag; valid with mN_ack.
REQ-013 mN_rdata  out  DATA_WIDTH  read data; held until the next mN_ack.
REQ-014 mc_we, mc_re  out  1  one-cycle command strobes to the memory controller.
REQ-015 mc_addr  out  ADDR_WIDTH_EXT  command address; mc_data_in  out  DATA_WIDTH  command write data.
REQ-016 mc_data_out  in  DATA_WIDTH  read data from the controller; mc_busy, mc_done  in  1  controller status.
REQ-017 arb_busy  out  1  high whenever state is not IDLE.

Function
REQ-018 State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; 2-bit state; illegal encodings go to IDLE.
REQ-019 IDLE, transition: if any mN_req=1 and mc_busy=0, the winner's we/addr/wdata and index SHALL be latched, and state goes to ISSUE.
REQ-020 IDLE, hold: otherwise the block stays in IDLE.
REQ-021 Arbitration is round-robin:
  - Single requester: that requester wins.
  - Both requesting: the port not granted last wins.
  - The last-grant pointer resets to 1, so m0 wins the first contest.
REQ-022 ISSUE: exactly one of mc_we/mc_re SHALL be high for exactly one cycle, with mc_addr/mc_data_in set to the latched values; state goes to WAIT.
REQ-023 mc_addr and mc_data_in SHALL hold their latched values until the next ISSUE.
REQ-024 WAIT, on mc_done=1:
  - For a read, mc_data_out is captured into the winner's rdata.
  - err is cleared; state goes to RESP.
REQ-025 mc_done outside WAIT SHALL be ignored.
REQ-026 RESP: the winner's mN_ack=1 for exactly this cycle; the last-grant pointer updates to the winner; state goes to IDLE.
REQ-027 A write ack SHALL leave mN_rdata unchanged.
REQ-028 Requester rule: mN_req drops on the clock edge that samples mN_ack=1. The IDLE cycle after RESP therefore never re-grants the same transaction.
REQ-029 Latency, minimum request-to-ack: IDLE(1)+ISSUE(1)+controller latency+RESP(1).
REQ-030 Latency, turnaround: back-to-back grants are separated by at least one IDLE cycle.
REQ-031 Dropping mN_req before ack is a protocol violation. The arbiter SHALL still complete the latched transaction and pulse ack.
REQ-032 The non-winning requester's latched values and rdata SHALL be unaffected by a transaction.

Reset
REQ-033 On reset=1 at a clock edge:
  - state=IDLE, last-grant=1, watchdog counter=0.
  - All mN_ack, mN_err, mN_rdata, mc_we, mc_re, mc_addr, mc_data_in and arb_busy outputs = 0.
REQ-034 Reset mid-transaction SHALL abort with no ack pulse. A later mc_done is ignored, and the next grant waits for mc_busy=0.

Configuration
REQ-035 Macro MEM_ARB_TIMEOUT_EN, when defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no mc_done, the winner gets mN_err=1 and mN_rdata=0, and state goes to RESP.
  - mc_done arriving in the same cycle as the limit takes precedence (normal completion, err=0).
REQ-036 Macro MEM_ARB_TIMEOUT_EN, when undefined: no counter is built, mN_err is tied to 0, and WAIT waits indefinitely.

Verification
REQ-037 m0 write, addr=0x00010, wdata=0xA5; controller done 3 cycles after strobe -> mc_we pulses once with addr 0x00010 and data 0xA5, then m0_ack=1 and m0_err=0.
REQ-038 m1 read, addr=0x12345; controller returns 0x3C -> mc_re pulses once, m1_rdata=0x3C at m1_ack and held afterward.
REQ-039 m0 and m1 both assert continuously for 4 transactions after reset -> grant order m0, m1, m0, m1, with exactly one IDLE cycle between each RESP and the next ISSUE.
REQ-040 mc_busy=1 held for 10 cycles while m0_req=1 -> no strobe during that time; ISSUE occurs in the cycle after the IDLE cycle that first sees mc_busy=0.
REQ-041 MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and mc_done never asserted -> m0_ack=1 with m0_err=1 and m0_rdata=0 four cycles into WAIT; a late mc_done is ignored.
REQ-042 reset asserted in WAIT, then mc_done arrives -> no ack pulse, all outputs 0, state IDLE.
